// File: rtl/gen_serial_adder.sv
// -----------------------------------------------------------------------------
// gen_serial_adder
//
// Purpose:
//   Multi-cycle adder/subtractor. An N-bit operation is split into K = N/W
//   chunks of W bits. One chunk is processed per clock, least significant
//   chunk first. The carry ripples between chunks through a register.
//   Subtraction is computed as a + ~b + 1: B is inverted when it is captured,
//   and the +1 is the initial carry-in.
//
// Parameters:
//   N  operand width in bits (>= 1)
//   W  chunk width added per clock (1 <= W <= N, N divisible by W)
//
// Ports:
//   clk    in   1    rising-edge clock
//   rst    in   1    synchronous active-high reset, overrides everything
//   start  in   1    begin an operation; accepted in IDLE or DONE only
//   sub    in   1    mode, captured with start: 0 = a+b, 1 = a-b
//   a      in   N    operand A, captured with start
//   b      in   N    operand B, captured with start
//   busy   out  1    high while the chunks are being processed (RUN)
//   done   out  1    one-cycle pulse; sum is valid while it is high
//   sum    out  N+1  result; sum[N] is the carry-out (1 = no borrow in sub)
//
// Timing:
//   done rises K edges after the edge that accepted start. If start is held
//   high, operations run back to back with a period of K+1 cycles.
// -----------------------------------------------------------------------------
module gen_serial_adder #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N:0]   sum
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int K  = N / W;
  // The counter needs at least one bit, even when K = 1.
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Reject illegal parameter sets at elaboration time.
  generate
    if (N < 1) begin : g_bad_n
      $error("gen_serial_adder: N must be >= 1");
    end
    if ((W < 1) || (W > N)) begin : g_bad_w
      $error("gen_serial_adder: W must satisfy 1 <= W <= N");
    end else if ((N % W) != 0) begin : g_bad_div
      $error("gen_serial_adder: N must be a multiple of W");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [N-1:0]  r_a;        // captured operand A
  logic [N-1:0]  r_b;        // captured B' (already inverted in sub mode)
  logic [CW-1:0] r_cnt;      // index of the chunk processed on the next RUN edge
  logic          r_carry;    // carry into the current chunk
  logic [N:0]    r_sum;

  // ---------------------------------------------------------------------------
  // Chunk slicing and selection
  // ---------------------------------------------------------------------------
  logic [W-1:0] w_a_chunk [K];
  logic [W-1:0] w_b_chunk [K];

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_chunk
      assign w_a_chunk[gi] = r_a[gi*W +: W];
      assign w_b_chunk[gi] = r_b[gi*W +: W];
    end
  endgenerate

  logic [W-1:0] w_a_sel;
  logic [W-1:0] w_b_sel;

  // The mux uses a comparison loop instead of a direct array index. This
  // keeps the select well defined when K is not a power of two. It also
  // covers K = 1, where the counter is wider than the index.
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < K; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_sel = w_a_chunk[i];
        w_b_sel = w_b_chunk[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Chunk adder: W-bit add with carry-in. Bit W is the chunk carry-out.
  // ---------------------------------------------------------------------------
  logic [W:0] w_chunk_add;
  logic       w_last;

  assign w_chunk_add = {1'b0, w_a_sel} + {1'b0, w_b_sel} + {{W{1'b0}}, r_carry};
  assign w_last      = (r_cnt == LAST_CHUNK);

  // Next sum in RUN: only the current chunk's bits change. On the final
  // chunk the carry-out also lands in sum[N].
  logic [N:0] w_sum_next;

  always_comb begin
    w_sum_next = r_sum;
    for (int i = 0; i < K; i++) begin
      if (r_cnt == CW'(i)) begin
        w_sum_next[i*W +: W] = w_chunk_add[W-1:0];
      end
    end
    if (w_last) begin
      w_sum_next[N] = w_chunk_add[W];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A new request is accepted directly from DONE. This lets a
          // held-high start run operations back to back.
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;          // the +1 of two's-complement negation
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          // start is ignored here; the captured operands stay as they are.
          r_sum   <= w_sum_next;
          r_carry <= w_chunk_add[W];
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;

endmodule

// File: tb/tb_gen_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_gen_serial_adder
//
// Three instances are used: N=8/W=2 (directed), N=6/W=3 and N=4/W=4
// (exhaustive). The expected sum and the issue cycle are queued when a start
// is driven. When done is seen, the oldest entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_gen_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       s8_start, s8_sub, s8_busy, s8_done;
  logic [7:0] s8_a, s8_b;
  logic [8:0] s8_sum;

  logic       s6_start, s6_sub, s6_busy, s6_done;
  logic [5:0] s6_a, s6_b;
  logic [6:0] s6_sum;

  logic       s4_start, s4_sub, s4_busy, s4_done;
  logic [3:0] s4_a, s4_b;
  logic [4:0] s4_sum;

  gen_serial_adder #(.N(8), .W(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub), .a(s8_a), .b(s8_b),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum)
  );

  gen_serial_adder #(.N(6), .W(3)) u_dut6 (
    .clk(clk), .rst(rst), .start(s6_start), .sub(s6_sub), .a(s6_a), .b(s6_b),
    .busy(s6_busy), .done(s6_done), .sum(s6_sum)
  );

  gen_serial_adder #(.N(4), .W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .sub(s4_sub), .a(s4_a), .b(s4_b),
    .busy(s4_busy), .done(s4_done), .sum(s4_sum)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and checking
  // ---------------------------------------------------------------------------
  typedef struct {
    int unsigned exp_sum;
    int unsigned issue;
  } exp_t;

  exp_t        sb [3][$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          held_mode = 1'b0;
  int unsigned prev_done8 = 0;
  int          k_of [3] = '{4, 2, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: an (n+1)-bit result of a+b or a+~b+1.
  function automatic int unsigned ref_model(input int n, input bit s,
                                            input int unsigned a, input int unsigned b);
    int unsigned mask;
    mask = (32'd1 << n) - 1;
    if (s) return a + ((~b) & mask) + 1;
    return a + b;
  endfunction

  task automatic push(input int d, input int n, input bit s,
                      input int unsigned a, input int unsigned b);
    exp_t e;
    e.exp_sum = ref_model(n, s, a, b);
    e.issue   = cyc;
    sb[d].push_back(e);
    $display("issue dut%0d sub=%0d a=%0h b=%0h exp=%0h", d, s, a, b, e.exp_sum);
  endtask

  // Monitor: a start driven at a negedge with cyc=c is accepted at edge c+1.
  // done then becomes visible at the negedge with cyc=c+1+K.
  always @(negedge clk) begin : monitor
    logic [31:0] dn [3];
    logic [31:0] sm [3];
    exp_t        e;
    dn[0] = {31'b0, s8_done}; sm[0] = {23'b0, s8_sum};
    dn[1] = {31'b0, s6_done}; sm[1] = {25'b0, s6_sum};
    dn[2] = {31'b0, s4_done}; sm[2] = {27'b0, s4_sum};
    for (int d = 0; d < 3; d++) begin
      if (dn[d] === 32'd1) begin
        if (sb[d].size() == 0) begin
          chk($sformatf("spurious_done%0d", d), 32'd1, 32'd0);
        end else begin
          e = sb[d].pop_front();
          if (d == 0)
            $display("done dut0 sum=%0h exp=%0h", sm[d], e.exp_sum);
          chk($sformatf("sum%0d", d), sm[d], e.exp_sum);
          chk($sformatf("latency%0d", d), cyc - e.issue, k_of[d] + 1);
        end
        if (d == 0) begin
          if (held_mode && prev_done8 != 0)
            chk("period8", cyc - prev_done8, 32'd5);
          prev_done8 = cyc;
        end
      end
    end
  end

  // Run one isolated N=8 operation and wait until the FSM is back in IDLE.
  task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b);
    s8_start = 1'b1; s8_sub = s; s8_a = a; s8_b = b;
    push(0, 8, s, a, b);
    @(negedge clk);
    s8_start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    s8_start = 0; s8_sub = 0; s8_a = 0; s8_b = 0;
    s6_start = 0; s6_sub = 0; s6_a = 0; s6_b = 0;
    s4_start = 0; s4_sub = 0; s4_a = 0; s4_b = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy8", {31'b0, s8_busy}, 0);
    chk("rst_done8", {31'b0, s8_done}, 0);
    chk("rst_sum8",  {23'b0, s8_sum}, 0);
    chk("rst_sum6",  {25'b0, s6_sum}, 0);
    chk("rst_sum4",  {27'b0, s4_sum}, 0);

    // FF + 01: busy for 4 cycles, then a one-cycle done with sum 100.
    s8_start = 1'b1; s8_sub = 1'b0; s8_a = 8'hFF; s8_b = 8'h01;
    push(0, 8, 1'b0, 8'hFF, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      s8_start = 1'b0;
      chk($sformatf("busy_run%0d", k), {31'b0, s8_busy}, 1);
      chk($sformatf("done_run%0d", k), {31'b0, s8_done}, 0);
    end
    @(negedge clk);
    chk("busy_in_done", {31'b0, s8_busy}, 0);
    chk("done_pulse",   {31'b0, s8_done}, 1);
    chk("sum_100",      {23'b0, s8_sum}, 32'h100);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, s8_done}, 0);
    chk("sum_hold_idle",  {23'b0, s8_sum}, 32'h100);

    // Subtraction with and without borrow.
    run8(1'b1, 8'd5, 8'd3);
    chk("sub_5_3_hold", {23'b0, s8_sum}, 32'h102);
    run8(1'b1, 8'd3, 8'd5);
    chk("sub_3_5_hold", {23'b0, s8_sum}, 32'h0FE);

    // Reset on the 2nd RUN cycle discards the operation without a done pulse.
    s8_start = 1'b1; s8_sub = 1'b0; s8_a = 8'h33; s8_b = 8'h44;
    @(negedge clk);
    s8_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'b0, s8_busy}, 0);
    chk("midrst_done", {31'b0, s8_done}, 0);
    chk("midrst_sum",  {23'b0, s8_sum}, 0);
    repeat (5) @(negedge clk);
    run8(1'b0, 8'h10, 8'h20);

    // A start pulse during RUN is ignored.
    s8_start = 1'b1; s8_sub = 1'b0; s8_a = 8'd5; s8_b = 8'd9;
    push(0, 8, 1'b0, 8'd5, 8'd9);
    @(negedge clk);
    s8_start = 1'b0;
    @(negedge clk);
    s8_start = 1'b1; s8_sub = 1'b1; s8_a = 8'hAA; s8_b = 8'h55;
    @(negedge clk);
    s8_start = 1'b0;
    repeat (4) @(negedge clk);

    // start held high: back-to-back operations, one every K+1 = 5 cycles.
    held_mode  = 1'b1;
    prev_done8 = 0;
    for (int i = 0; i < 6; i++) begin
      s8_start = 1'b1;
      s8_sub   = 1'($urandom_range(0, 1));
      s8_a     = 8'($urandom_range(0, 255));
      s8_b     = 8'($urandom_range(0, 255));
      push(0, 8, s8_sub, s8_a, s8_b);
      repeat (5) @(negedge clk);
    end
    s8_start = 1'b0;
    repeat (6) @(negedge clk);
    held_mode = 1'b0;

    // Exhaustive sweeps on the two smaller configurations, in parallel.
    fork
      begin
        for (int ia = 0; ia < 64; ia++)
          for (int ib = 0; ib < 64; ib++)
            for (int s = 0; s < 2; s++) begin
              s6_start = 1'b1; s6_sub = 1'(s); s6_a = 6'(ia); s6_b = 6'(ib);
              push(1, 6, 1'(s), ia, ib);
              @(negedge clk);
              s6_start = 1'b0;
              repeat (3) @(negedge clk);
            end
      end
      begin
        for (int ia = 0; ia < 16; ia++)
          for (int ib = 0; ib < 16; ib++)
            for (int s = 0; s < 2; s++) begin
              s4_start = 1'b1; s4_sub = 1'(s); s4_a = 4'(ia); s4_b = 4'(ib);
              push(2, 4, 1'(s), ia, ib);
              @(negedge clk);
              s4_start = 1'b0;
              repeat (2) @(negedge clk);
            end
      end
    join

    repeat (10) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("drain%0d", d), sb[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so a stuck design cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gen_serial_adder.md
GEN_SERIAL_ADDER -- requirements
Module: gen_serial_adder

Interface
REQ-001 Parameter N, default 8: operand width in bits; N SHALL be >= 1.
REQ-002 Parameter W, default 2: chunk width added per clock; 1 <= W <= N and N mod W = 0, otherwise elaboration SHALL fail.
REQ-003 Derived constant K = N/W SHALL be the number of RUN cycles per operation.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to begin an operation, sampled on rising edge.
REQ-007 sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b.
REQ-008 a  input  N  operand A, sampled with start.
REQ-009 b  input  N  operand B, sampled with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking a valid result.
REQ-012 sum  output  N+1  result; bit N is the carry-out.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL latch a, b and sub, clear the chunk counter, load carry-in = sub, and enter RUN.
REQ-015 In IDLE or DONE, start=0 at an edge SHALL leave sum unchanged.
REQ-016 start SHALL be ignored while in RUN; latched operands and mode SHALL not change.
REQ-017 In RUN, each edge SHALL add chunk i of A to chunk i of B', LSB chunk first.
REQ-018 B' SHALL be B when sub=0 and ~B when sub=1.
REQ-019 Each RUN edge SHALL write the W-bit chunk result into sum bits [i*W+W-1 : i*W] and register the chunk carry-out for chunk i+1.
REQ-020 On the K-th RUN edge the FSM SHALL write the final carry to sum[N] and enter DONE.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE unless REQ-014 applies.
REQ-022 Add mode: sum SHALL equal a+b as an (N+1)-bit result.
REQ-023 Sub mode: sum SHALL equal a + ~b + 1 as an (N+1)-bit result. sum[N]=1 means a>=b (no borrow); sum[N]=0 means borrow and the low N bits hold the two's-complement difference.
REQ-024 done SHALL be 1 only in DONE, exactly K clock edges after the edge that captured start.
REQ-025 busy SHALL be 1 only in RUN.
REQ-026 sum SHALL hold the last result from DONE until the next accepted start's first RUN edge.
REQ-027 sum SHALL be read only when done=1; intermediate values during RUN are undefined for consumers.
REQ-028 When W=N (K=1), done SHALL assert on the edge after the start edge.
REQ-029 start held high continuously SHALL give back-to-back operations with period K+1 cycles (K RUN + 1 DONE).
REQ-030 The chunk counter SHALL wrap from K-1 only by leaving RUN; it SHALL never index beyond chunk K-1.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, sum=0, carry register=0 and chunk counter=0.
REQ-032 rst SHALL take priority over start in every state, including mid-RUN; any operation in progress SHALL be discarded without a done pulse.
REQ-033 After rst deasserts, the first accepted start SHALL behave exactly as from power-up IDLE.

Verification
REQ-034 N=8, W=2, add, a=8'hFF, b=8'h01, start for one cycle -> busy high for 4 cycles, then done pulse for 1 cycle with sum=9'h100.
REQ-035 N=8, W=2, sub, a=5, b=3 -> sum=9'h102. Then sub, a=3, b=5 -> sum=9'h0FE (borrow indicated by sum[8]=0).
REQ-036 N=8, W=2, rst pulsed on the 2nd RUN cycle -> busy=0, done=0, sum=0 next cycle; no done pulse. The following start with a=8'h10, b=8'h20 -> sum=9'h030.
REQ-037 N=8, W=2, start re-pulsed with different operands during RUN -> ignored; result matches the first operands. Start held high -> done pulses every 5 cycles.
REQ-038 N=6, W=3 and N=4, W=4: exhaustive loop over all {a,b} for both modes, one operation at a time -> every sum matches the REQ-022 / REQ-023 reference model, with done exactly K edges after start.
